ysyx_23060025_mem_stage: RTL and testbench
==========================================

// Module: ysyx_23060025_mem_stage
// PURPOSE
//  Memory (LSU) stage: receiving end of es_to_ms_bus / es_to_lsu_valid / lsu_allowin from the EX stage.
//  Latches one instruction, performs at most one load/store on the data port, then aligns and extends
//  load data. Hands the result to WB over ms_to_ws_bus with the same valid/allowin handshake.
//  Drives a forwarding/stall bus back to ID.
// PARAMETERS
//  DATA_LEN  32  datapath width; only 32 is supported.
// PORTS
//  clock                 in   1    single clock
//  reset                 in   1    asynchronous, active-low
//  es_to_ms_bus          in   189  {pc32,wd,wreg5,alu_res32,mem_wen,st_data32,load_type3,store_type2,
//                                   csr_wdata32,csr_flag3,csr_waddr12,csr_mcause32,ebreak,fencei}
//  es_to_lsu_valid_i     in   1    EX holds a valid instruction for MS
//  lsu_allowin_o         out  1    MS accepts this cycle
//  ms_valid_o            out  1    MS holds a live instruction
//  ms_to_ws_valid_o      out  1    result valid toward WB
//  ws_allowin_i          in   1    WB accepts
//  ms_to_ws_bus          out  152  {pc,wd,wreg,final_res32,csr_wdata,csr_flag,csr_waddr,csr_mcause,ebreak,fencei,misalign}
//  ms_to_ds_forward_bus  out  87   {dep_need_stall,fwd_en,wreg5,final_res32,csr_fwd_en,csr_waddr12,csr_wdata32,csr_flag3}
//  fencei_flush_sign_i   in   1    flush request
//  fencei_flush_valid_i  in   1    qualifies flush_sign; flush = sign & valid
//  data_req_o            out  1    data-port request; once raised, held until data_ready_i
//  data_we_o             out  1    1 = store
//  data_addr_o           out  32   {alu_res[31:2],2'b00}
//  data_wstrb_o          out  4    byte strobes
//  data_wdata_o          out  32   lane-aligned store data
//  data_ready_i          in   1    request accepted
//  data_rvalid_i         in   1    response (load data or store ack)
//  data_rdata_i          in   32   load data, word aligned
// BEHAVIOUR
//  Reset (async, reset==0): state=IDLE; ms_valid_o, data_req_o, ms_to_ws_valid_o = 0; bus register, rdata register = 0.
//  Accept: es_to_lsu_valid_i & lsu_allowin_o latches the bus and sets ms_valid_o.
//   Next state is REQ if load_type!=0 or store_type!=0; otherwise DONE.
//  FSM:
//   IDLE -> (accept) REQ|DONE
//   REQ:  data_req_o=1; data_ready_i -> WAIT
//   WAIT: data_rvalid_i -> DONE; rdata captured on loads
//   DONE: ms_ready_go=1; on ws_allowin_i, -> REQ|DONE if a new accept happens the same cycle, else IDLE.
//  lsu_allowin_o = !ms_valid_o | (state==DONE & ws_allowin_i); ms_to_ws_valid_o = ms_valid_o & state==DONE & !flush.
//  Latency from accept to ms_to_ws_valid_o (zero-wait memory: ready in REQ, rvalid the next cycle):
//   non-mem 1 cycle; mem 3 cycles. Back-to-back non-mem runs at 1 per cycle.
//  Store: SB wstrb=0001<<a, wdata={4{d[7:0]}}; SH wstrb=0011<<a, wdata={2{d[15:0]}}; SW wstrb=1111. a=alu_res[1:0].
//  Load: w=rdata>>(8*a); LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged. final_res=load?ext:alu_res.
//  Encodings: load_type 0 none,1 LB,2 LH,3 LW,4 LBU,5 LHU; store_type 0 none,1 SB,2 SH,3 SW.
//  Forwarding:
//   fwd_en = ms_valid_o & wd & wreg!=0.
//   dep_need_stall = ms_valid_o & load & state!=DONE.
//   csr_fwd_en = ms_valid_o & csr_flag in {CSRRW,CSRRS,ECALL}.
//  Flush:
//   In IDLE/DONE: ms_valid_o=0 next cycle.
//   In REQ/WAIT: request held to handshake; rvalid awaited; then ms_valid_o=0, state IDLE.
//    Result is dropped, no write to WB; lsu_allowin_o=0 while draining.
//  Simultaneous rvalid and ws_allowin_i in WAIT: result is registered first; handoff occurs in DONE.
//  WB stall in DONE: bus and result held stable; no new data-port request issued.
// CONFIGURATION
//  YSYX_23060025_MISALIGN_TRAP_EN defined:
//   LH/LHU/SH with a[0]!=0, or LW/SW with a!=0, go straight to DONE, raise no data_req_o, and set misalign=1.
//  Undefined: misalign is tied to 0 and the access is issued with the a-based strobes and shifts.
//   Bytes beyond the word are dropped.
// STRUCTURE
//  Shared define header gets:
//   `ES_TO_MS_DATA_BUS 189, `MS_TO_WS_DATA_BUS 152, `MS_TO_DS_FORWARD_BUS 87
//   load/store type encodings; FSM state constants.
//  One sub-module: ysyx_23060025_lsu_align (combinational store lane/strobe generation and load extract/extend).
// TESTING
//  1. ALU-only add, wd=1, wreg=5, alu_res=0x1234, ws_allowin=1 -> ms_to_ws_valid 1 cycle after accept; final_res=0x1234; fwd_en=1.
//  2. LB at 0x80000003, rdata=0x80FF_0000 -> addr 0x80000000; final_res=0xFFFFFF80; dep_need_stall=1 until DONE.
//  3. SH at 0x..2, st_data=0xABCD -> wstrb=1100, wdata=0xABCDABCD, data_we=1; WB gets final_res=alu_res.
//  4. data_ready_i held low 5 cycles -> data_req_o stays 1 with stable addr/wstrb/wdata; lsu_allowin_o=0 throughout.
//  5. Flush in WAIT -> no ms_to_ws_valid; state IDLE the cycle after rvalid; next accept proceeds normally.
//  6. reset asserted in WAIT -> data_req_o=0, ms_valid_o=0 immediately; late rvalid after release is ignored.

Source files
------------

// File: rtl/ysyx_23060025_mem_stage_pkg.sv
// Shared types and constants for the memory (LSU) stage: bus widths,
// load/store encodings, CSR op encodings, the FSM state type and the
// input bus layout.
package ysyx_23060025_mem_stage_pkg;

  localparam int unsigned ES_TO_MS_DATA_BUS    = 189;
  localparam int unsigned MS_TO_WS_DATA_BUS    = 152;
  localparam int unsigned MS_TO_DS_FORWARD_BUS = 87;

  localparam logic [2:0] LD_NONE = 3'd0;
  localparam logic [2:0] LD_LB   = 3'd1;
  localparam logic [2:0] LD_LH   = 3'd2;
  localparam logic [2:0] LD_LW   = 3'd3;
  localparam logic [2:0] LD_LBU  = 3'd4;
  localparam logic [2:0] LD_LHU  = 3'd5;

  localparam logic [1:0] ST_NONE = 2'd0;
  localparam logic [1:0] ST_SB   = 2'd1;
  localparam logic [1:0] ST_SH   = 2'd2;
  localparam logic [1:0] ST_SW   = 2'd3;

  localparam logic [2:0] CSR_NONE  = 3'd0;
  localparam logic [2:0] CSR_RW    = 3'd1;
  localparam logic [2:0] CSR_RS    = 3'd2;
  localparam logic [2:0] CSR_ECALL = 3'd3;
  localparam logic [2:0] CSR_MRET  = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } ms_state_e;

  // Field order matches es_to_ms_bus, MSB first.
  typedef struct packed {
    logic [31:0] pc;
    logic        wd;
    logic [4:0]  wreg;
    logic [31:0] alu_res;
    logic        mem_wen;
    logic [31:0] st_data;
    logic [2:0]  load_type;
    logic [1:0]  store_type;
    logic [31:0] csr_wdata;
    logic [2:0]  csr_flag;
    logic [11:0] csr_waddr;
    logic [31:0] csr_mcause;
    logic        ebreak;
    logic        fencei;
  } es_to_ms_t;

  // Halfword accesses need a[0]==0, word accesses need a==0.
  function automatic logic is_misaligned(input logic [2:0] ld, input logic [1:0] st,
                                         input logic [1:0] a);
    logic half;
    logic word;
    half = (ld == LD_LH) || (ld == LD_LHU) || (st == ST_SH);
    word = (ld == LD_LW) || (st == ST_SW);
    return (half && a[0]) || (word && (a != 2'b00));
  endfunction

endpackage

// File: rtl/ysyx_23060025_mem_stage_lsu_align.sv
// Combinational lane steering: store byte strobes / replicated write data,
// and load data extraction with sign/zero extension.
module ysyx_23060025_lsu_align
  import ysyx_23060025_mem_stage_pkg::*;
(
  input  logic [2:0]  load_type,
  input  logic [1:0]  store_type,
  input  logic [1:0]  offset,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_res
);

  logic [31:0] shifted;

  // Store strobes shift with the byte offset; strobes past byte 3 fall off the word.
  always_comb begin
    wstrb = '0;
    wdata = st_data;
    unique case (store_type)
      ST_SB: begin
        wstrb = 4'b0001 << offset;
        wdata = {4{st_data[7:0]}};
      end
      ST_SH: begin
        wstrb = 4'b0011 << offset;
        wdata = {2{st_data[15:0]}};
      end
      ST_SW: wstrb = 4'b1111;
      default: ;
    endcase
  end

  // Bring the addressed byte to lane 0, then extend to 32 bits.
  always_comb begin
    shifted  = rdata >> {offset, 3'b000};
    load_res = shifted;
    unique case (load_type)
      LD_LB:   load_res = {{24{shifted[7]}}, shifted[7:0]};
      LD_LH:   load_res = {{16{shifted[15]}}, shifted[15:0]};
      LD_LBU:  load_res = {24'h0, shifted[7:0]};
      LD_LHU:  load_res = {16'h0, shifted[15:0]};
      default: load_res = shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_23060025_mem_stage.sv
// Memory (LSU) stage: latches one instruction from EX, performs at most one
// data-port access, aligns/extends load data and hands the result to WB.
// Optional feature macro: YSYX_23060025_MISALIGN_TRAP_EN (misaligned
// halfword/word accesses skip the data port and flag misalign).
module ysyx_23060025_mem_stage
  import ysyx_23060025_mem_stage_pkg::*;
#(
  parameter int unsigned DATA_LEN = 32
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [ES_TO_MS_DATA_BUS-1:0]    es_to_ms_bus,
  input  logic                            es_to_lsu_valid_i,
  output logic                            lsu_allowin_o,
  output logic                            ms_valid_o,
  output logic                            ms_to_ws_valid_o,
  input  logic                            ws_allowin_i,
  output logic [MS_TO_WS_DATA_BUS-1:0]    ms_to_ws_bus,
  output logic [MS_TO_DS_FORWARD_BUS-1:0] ms_to_ds_forward_bus,
  input  logic                            fencei_flush_sign_i,
  input  logic                            fencei_flush_valid_i,
  output logic                            data_req_o,
  output logic                            data_we_o,
  output logic [DATA_LEN-1:0]             data_addr_o,
  output logic [3:0]                      data_wstrb_o,
  output logic [DATA_LEN-1:0]             data_wdata_o,
  input  logic                            data_ready_i,
  input  logic                            data_rvalid_i,
  input  logic [DATA_LEN-1:0]             data_rdata_i
);

  es_to_ms_t     in_bus, bus_q, bus_d;
  ms_state_e     state_q, state_d;
  logic          ms_valid_q, ms_valid_d;
  logic          data_req_q, data_req_d;
  logic          flushed_q, flushed_d;
  logic [DATA_LEN-1:0] rdata_q, rdata_d;

  logic          flush, accept, ready_go;
  logic          is_load, is_store, misalign;
  logic          in_mem, in_mis, start_req;
  logic [31:0]   load_res, final_res;
  logic [3:0]    wstrb;
  logic [31:0]   wdata;

  assign in_bus   = es_to_ms_t'(es_to_ms_bus);
  assign flush    = fencei_flush_sign_i & fencei_flush_valid_i;
  assign ready_go = (state_q == S_DONE);
  assign lsu_allowin_o = !ms_valid_q | (ready_go & ws_allowin_i);
  assign accept   = es_to_lsu_valid_i & lsu_allowin_o;
  assign is_load  = (bus_q.load_type != LD_NONE);
  assign is_store = (bus_q.store_type != ST_NONE);
  assign in_mem   = (in_bus.load_type != LD_NONE) || (in_bus.store_type != ST_NONE);

`ifdef YSYX_23060025_MISALIGN_TRAP_EN
  assign in_mis   = is_misaligned(in_bus.load_type, in_bus.store_type, in_bus.alu_res[1:0]);
  assign misalign = is_misaligned(bus_q.load_type, bus_q.store_type, bus_q.alu_res[1:0]);
`else
  assign in_mis   = 1'b0;
  assign misalign = 1'b0;
`endif

  assign start_req = in_mem & !in_mis;

  ysyx_23060025_lsu_align u_align (
    .load_type (bus_q.load_type),
    .store_type(bus_q.store_type),
    .offset    (bus_q.alu_res[1:0]),
    .st_data   (bus_q.st_data),
    .rdata     (rdata_q),
    .wstrb     (wstrb),
    .wdata     (wdata),
    .load_res  (load_res)
  );

  // Next-state: accept/handoff, data-port handshake, and flush draining.
  // A flush seen in REQ/WAIT is remembered so the access completes and the
  // response is swallowed before the stage frees up.
  always_comb begin
    state_d    = state_q;
    ms_valid_d = ms_valid_q;
    data_req_d = data_req_q;
    flushed_d  = flushed_q;
    bus_d      = bus_q;
    rdata_d    = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept && !flush) begin
          bus_d      = in_bus;
          ms_valid_d = 1'b1;
          data_req_d = start_req;
          state_d    = start_req ? S_REQ : S_DONE;
        end
      end
      S_REQ: begin
        if (flush) flushed_d = 1'b1;
        if (data_ready_i) begin
          data_req_d = 1'b0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) flushed_d = 1'b1;
        if (data_rvalid_i) begin
          if (flushed_q || flush) begin
            state_d    = S_IDLE;
            ms_valid_d = 1'b0;
            flushed_d  = 1'b0;
          end else begin
            state_d = S_DONE;
            if (is_load) rdata_d = data_rdata_i;
          end
        end
      end
      S_DONE: begin
        if (flush) begin
          state_d    = S_IDLE;
          ms_valid_d = 1'b0;
        end else if (ws_allowin_i) begin
          if (accept) begin
            bus_d      = in_bus;
            ms_valid_d = 1'b1;
            data_req_d = start_req;
            state_d    = start_req ? S_REQ : S_DONE;
          end else begin
            state_d    = S_IDLE;
            ms_valid_d = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  // State and datapath registers, cleared by the asynchronous reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      ms_valid_q <= 1'b0;
      data_req_q <= 1'b0;
      flushed_q  <= 1'b0;
      bus_q      <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      ms_valid_q <= ms_valid_d;
      data_req_q <= data_req_d;
      flushed_q  <= flushed_d;
      bus_q      <= bus_d;
      rdata_q    <= rdata_d;
    end
  end

  assign final_res        = (is_load && !misalign) ? load_res : bus_q.alu_res;
  assign ms_valid_o       = ms_valid_q;
  assign ms_to_ws_valid_o = ms_valid_q & ready_go & !flush;

  assign data_req_o   = data_req_q;
  assign data_we_o    = bus_q.mem_wen;
  assign data_addr_o  = {bus_q.alu_res[31:2], 2'b00};
  assign data_wstrb_o = wstrb;
  assign data_wdata_o = wdata;

  assign ms_to_ws_bus = {bus_q.pc, bus_q.wd, bus_q.wreg, final_res,
                         bus_q.csr_wdata, bus_q.csr_flag, bus_q.csr_waddr,
                         bus_q.csr_mcause, bus_q.ebreak, bus_q.fencei, misalign};

  assign ms_to_ds_forward_bus = {
    ms_valid_q & is_load & !ready_go,
    ms_valid_q & bus_q.wd & (bus_q.wreg != 5'd0),
    bus_q.wreg,
    final_res,
    ms_valid_q & ((bus_q.csr_flag == CSR_RW) || (bus_q.csr_flag == CSR_RS) ||
                  (bus_q.csr_flag == CSR_ECALL)),
    bus_q.csr_waddr,
    bus_q.csr_wdata,
    bus_q.csr_flag
  };

endmodule

// File: tb/tb_ysyx_23060025_mem_stage.sv
// Directed bench for the memory stage (default build, misalign trap off).
module tb_ysyx_23060025_mem_stage;

  logic         clock;
  logic         reset;
  logic [188:0] es_bus;
  logic         es_valid;
  logic         lsu_allowin;
  logic         ms_valid;
  logic         to_ws_valid;
  logic         ws_allowin;
  logic [151:0] ws_bus;
  logic [86:0]  fwd_bus;
  logic         fl_sign, fl_valid;
  logic         data_req, data_we;
  logic [31:0]  data_addr;
  logic [3:0]   data_wstrb;
  logic [31:0]  data_wdata;
  logic         data_ready, data_rvalid;
  logic [31:0]  data_rdata;

  int unsigned  n_chk;
  int unsigned  n_bad;

  logic [31:0]  ws_final, ws_pc, fwd_res;
  logic         fwd_en, fwd_stall, fwd_csr_en, ws_misalign;
  logic [4:0]   fwd_wreg;

  assign ws_final    = ws_bus[113:82];
  assign ws_pc       = ws_bus[151:120];
  assign ws_misalign = ws_bus[0];
  assign fwd_stall   = fwd_bus[86];
  assign fwd_en      = fwd_bus[85];
  assign fwd_wreg    = fwd_bus[84:80];
  assign fwd_res     = fwd_bus[79:48];
  assign fwd_csr_en  = fwd_bus[47];

  ysyx_23060025_mem_stage #(.DATA_LEN(32)) dut (
    .clock               (clock),
    .reset               (reset),
    .es_to_ms_bus        (es_bus),
    .es_to_lsu_valid_i   (es_valid),
    .lsu_allowin_o       (lsu_allowin),
    .ms_valid_o          (ms_valid),
    .ms_to_ws_valid_o    (to_ws_valid),
    .ws_allowin_i        (ws_allowin),
    .ms_to_ws_bus        (ws_bus),
    .ms_to_ds_forward_bus(fwd_bus),
    .fencei_flush_sign_i (fl_sign),
    .fencei_flush_valid_i(fl_valid),
    .data_req_o          (data_req),
    .data_we_o           (data_we),
    .data_addr_o         (data_addr),
    .data_wstrb_o        (data_wstrb),
    .data_wdata_o        (data_wdata),
    .data_ready_i        (data_ready),
    .data_rvalid_i       (data_rvalid),
    .data_rdata_i        (data_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Fields: pc, wd, wreg, alu_res, mem_wen, st_data, load_type, store_type, csr_flag.
  function automatic logic [188:0] mk_es(input logic [31:0] pc, input logic wd,
                                         input logic [4:0] wreg, input logic [31:0] alu,
                                         input logic mem_wen, input logic [31:0] st,
                                         input logic [2:0] ld, input logic [1:0] sty,
                                         input logic [2:0] cflag);
    return {pc, wd, wreg, alu, mem_wen, st, ld, sty, 32'hC5C5_0001, cflag, 12'h305,
            32'h0000_000B, 1'b0, 1'b0};
  endfunction

  // Zero-wait load: accept, ready in REQ, rvalid in WAIT, then check the result in DONE.
  task automatic run_load(input string tag, input logic [188:0] bus, input logic [31:0] rd,
                          input logic [31:0] exp);
    es_bus = bus; es_valid = 1'b1; data_ready = 1'b1; ws_allowin = 1'b1;
    step();
    es_valid = 1'b0;
    step();
    data_rvalid = 1'b1; data_rdata = rd;
    step();
    data_rvalid = 1'b0; data_rdata = 32'h0;
    #1;
    chk({tag, "_valid"}, {31'h0, to_ws_valid}, 32'h1);
    chk(tag, ws_final, exp);
    chk({tag, "_mis"}, {31'h0, ws_misalign}, 32'h0);
    step();
  endtask

  initial begin
    n_chk = 0; n_bad = 0;
    reset = 1'b1; es_bus = '0; es_valid = 1'b0; ws_allowin = 1'b0;
    fl_sign = 1'b0; fl_valid = 1'b0;
    data_ready = 1'b0; data_rvalid = 1'b0; data_rdata = '0;
    #1 reset = 1'b0;
    #1;
    chk("rst_ctrl", {28'h0, ms_valid, data_req, to_ws_valid, lsu_allowin}, 32'h1);
    chk("rst_bus", ws_bus[31:0], 32'h0);
    #10 reset = 1'b1;
    step();

    // 1: ALU-only op, one cycle to WB
    es_bus = mk_es(32'h8000_0000, 1'b1, 5'd5, 32'h0000_1234, 1'b0, 32'h0, 3'd0, 2'd0, 3'd1);
    es_valid = 1'b1; ws_allowin = 1'b1;
    #1 chk("t1_allowin", {31'h0, lsu_allowin}, 32'h1);
    step();
    es_valid = 1'b0;
    #1;
    chk("t1_valid", {31'h0, to_ws_valid}, 32'h1);
    chk("t1_res", ws_final, 32'h0000_1234);
    chk("t1_pc", ws_pc, 32'h8000_0000);
    chk("t1_fwd", {25'h0, fwd_stall, fwd_en, fwd_wreg}, {25'h0, 1'b0, 1'b1, 5'd5});
    chk("t1_csrfwd", {31'h0, fwd_csr_en}, 32'h1);
    chk("t1_noreq", {31'h0, data_req}, 32'h0);
    step();
    chk("t1_idle", {31'h0, ms_valid}, 32'h0);

    // back-to-back ALU ops at one per cycle
    es_bus = mk_es(32'h8000_0010, 1'b1, 5'd3, 32'h0000_00AA, 1'b0, 32'h0, 3'd0, 2'd0, 3'd0);
    es_valid = 1'b1;
    step();
    es_bus = mk_es(32'h8000_0014, 1'b1, 5'd0, 32'h0000_00BB, 1'b0, 32'h0, 3'd0, 2'd0, 3'd0);
    #1;
    chk("b2b_a", ws_final, 32'h0000_00AA);
    chk("b2b_a_hs", {30'h0, to_ws_valid, lsu_allowin}, 32'h3);
    step();
    es_valid = 1'b0;
    #1;
    chk("b2b_b", ws_final, 32'h0000_00BB);
    chk("b2b_b_fwd", {30'h0, fwd_en, fwd_csr_en}, 32'h0);
    step();

    // 2: LB at 0x80000003
    es_bus = mk_es(32'h8000_0020, 1'b1, 5'd7, 32'h8000_0003, 1'b0, 32'h0, 3'd1, 2'd0, 3'd0);
    es_valid = 1'b1; data_ready = 1'b1;
    step();
    es_valid = 1'b0;
    #1;
    chk("t2_addr", data_addr, 32'h8000_0000);
    chk("t2_req", {28'h0, data_req, data_we, to_ws_valid, lsu_allowin}, 32'h8);
    chk("t2_stall_req", {31'h0, fwd_stall}, 32'h1);
    step();
    data_rvalid = 1'b1; data_rdata = 32'h80FF_0000;
    #1;
    chk("t2_wait", {30'h0, data_req, fwd_stall}, 32'h1);
    step();
    data_rvalid = 1'b0; data_rdata = 32'hDEAD_BEEF;
    #1;
    chk("t2_valid", {31'h0, to_ws_valid}, 32'h1);
    chk("t2_res", ws_final, 32'hFFFF_FF80);
    chk("t2_fwd_res", fwd_res, 32'hFFFF_FF80);
    chk("t2_stall_done", {31'h0, fwd_stall}, 32'h0);
    step();

    // other load widths and offsets
    run_load("lh", mk_es(32'h0, 1'b1, 5'd1, 32'h1000_0002, 1'b0, 32'h0, 3'd2, 2'd0, 3'd0),
             32'h8001_5555, 32'hFFFF_8001);
    run_load("lbu", mk_es(32'h0, 1'b1, 5'd1, 32'h1000_0001, 1'b0, 32'h0, 3'd4, 2'd0, 3'd0),
             32'h0000_F000, 32'h0000_00F0);
    run_load("lw", mk_es(32'h0, 1'b1, 5'd1, 32'h1000_0000, 1'b0, 32'h0, 3'd3, 2'd0, 3'd0),
             32'hCAFE_F00D, 32'hCAFE_F00D);
    run_load("lhu3", mk_es(32'h0, 1'b1, 5'd1, 32'h1000_0003, 1'b0, 32'h0, 3'd5, 2'd0, 3'd0),
             32'h1234_5678, 32'h0000_0012);

    // 3+4: SH at offset 2 with ready held low for 5 cycles
    es_bus = mk_es(32'h8000_0030, 1'b0, 5'd0, 32'h8000_1002, 1'b1, 32'h0000_ABCD, 3'd0, 2'd2, 3'd0);
    es_valid = 1'b1; data_ready = 1'b0;
    step();
    es_valid = 1'b0;
    #1;
    chk("t3_ctl", {25'h0, data_req, lsu_allowin, data_we, data_wstrb}, 32'h5C);
    chk("t3_wdata", data_wdata, 32'hABCD_ABCD);
    chk("t3_addr", data_addr, 32'h8000_1000);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_hold_ctl", {25'h0, data_req, lsu_allowin, data_we, data_wstrb}, 32'h5C);
      chk("t4_hold_wdata", data_wdata ^ data_addr, 32'hABCD_ABCD ^ 32'h8000_1000);
    end
    data_ready = 1'b1;
    step();
    data_ready = 1'b0; data_rvalid = 1'b1;
    #1 chk("t3_wait_req", {31'h0, data_req}, 32'h0);
    step();
    data_rvalid = 1'b0; ws_allowin = 1'b0;
    #1;
    chk("t3_valid", {31'h0, to_ws_valid}, 32'h1);
    chk("t3_res", ws_final, 32'h8000_1002);
    step();
    chk("wbstall", {29'h0, to_ws_valid, data_req, lsu_allowin}, 32'h4);
    chk("wbstall_res", ws_final, 32'h8000_1002);
    ws_allowin = 1'b1;
    step();
    chk("t3_idle", {31'h0, ms_valid}, 32'h0);

    // flush while in DONE with WB stalled
    es_bus = mk_es(32'h8000_0040, 1'b1, 5'd9, 32'h0000_0077, 1'b0, 32'h0, 3'd0, 2'd0, 3'd0);
    es_valid = 1'b1; ws_allowin = 1'b0;
    step();
    es_valid = 1'b0; fl_sign = 1'b1; fl_valid = 1'b1;
    #1 chk("fl_done_gate", {30'h0, ms_valid, to_ws_valid}, 32'h2);
    step();
    fl_sign = 1'b0; fl_valid = 1'b0; ws_allowin = 1'b1;
    #1 chk("fl_done_drop", {30'h0, ms_valid, lsu_allowin}, 32'h1);

    // 5: flush while waiting for rvalid
    es_bus = mk_es(32'h8000_0050, 1'b1, 5'd4, 32'h8000_2000, 1'b0, 32'h0, 3'd3, 2'd0, 3'd0);
    es_valid = 1'b1; data_ready = 1'b1;
    step();
    es_valid = 1'b0;
    step();
    fl_sign = 1'b1; fl_valid = 1'b1;
    #1 chk("t5_wait", {30'h0, to_ws_valid, lsu_allowin}, 32'h0);
    step();
    fl_sign = 1'b0; fl_valid = 1'b0; data_rvalid = 1'b1; data_rdata = 32'h1111_2222;
    #1 chk("t5_drain", {29'h0, ms_valid, to_ws_valid, lsu_allowin}, 32'h4);
    step();
    data_rvalid = 1'b0;
    #1 chk("t5_idle", {29'h0, ms_valid, to_ws_valid, lsu_allowin}, 32'h1);
    es_bus = mk_es(32'h8000_0054, 1'b1, 5'd6, 32'h0000_0055, 1'b0, 32'h0, 3'd0, 2'd0, 3'd0);
    es_valid = 1'b1;
    step();
    es_valid = 1'b0;
    #1;
    chk("t5_next_valid", {31'h0, to_ws_valid}, 32'h1);
    chk("t5_next_res", ws_final, 32'h0000_0055);
    step();

    // 6a: reset while the request is up
    es_bus = mk_es(32'h8000_0060, 1'b1, 5'd2, 32'h8000_0001, 1'b0, 32'h0, 3'd1, 2'd0, 3'd0);
    es_valid = 1'b1; data_ready = 1'b0;
    step();
    es_valid = 1'b0;
    #1 chk("t6_req_pre", {31'h0, data_req}, 32'h1);
    reset = 1'b0;
    #1 chk("t6_req_rst", {30'h0, ms_valid, data_req}, 32'h0);
    step();
    reset = 1'b1;

    // 6b: reset in WAIT, then a late rvalid
    es_valid = 1'b1; data_ready = 1'b1;
    step();
    es_valid = 1'b0;
    step();
    reset = 1'b0;
    #1 chk("t6_wait_rst", {29'h0, ms_valid, data_req, fwd_stall}, 32'h0);
    step();
    reset = 1'b1; data_rvalid = 1'b1; data_rdata = 32'h8080_8080;
    step();
    data_rvalid = 1'b0;
    #1;
    chk("t6_late", {29'h0, ms_valid, to_ws_valid, lsu_allowin}, 32'h1);
    chk("t6_bus", ws_final, 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
